// File: rtl/mining_job_scheduler_pkg.sv
// mining_job_scheduler_pkg: shared FSM encoding, default sizing and pointer-width helper
package mining_job_scheduler_pkg;
   localparam int CORE_NUM_DEF = 4;
   localparam int DATA_WID_DEF = 32;
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      RUN   = 3'd2,
      FULL  = 3'd3,
      ABORT = 3'd4
   } state_t;
   function automatic int ptr_wid(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/mining_job_scheduler_rr_arbiter.sv
// mining_job_scheduler_rr_arbiter: combinational round-robin pick of the first request at or after ptr
module mining_job_scheduler_rr_arbiter
   import mining_job_scheduler_pkg::*;
#(
   parameter int N = 4,
   localparam int IW = ptr_wid(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);
   // circular scan starting at ptr; the first set request wins
   always_comb begin
      int j;
      logic found;
      gnt = '0;
      gnt_idx = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!found && req[j]) begin
            found = 1'b1;
            gnt[j] = 1'b1;
            gnt_idx = IW'(j);
         end
      end
   end
endmodule

// File: rtl/mining_job_scheduler.sv
// mining_job_scheduler: splits the nonce space across cores, starts/aborts jobs, merges hits round-robin
module mining_job_scheduler
   import mining_job_scheduler_pkg::*;
#(
   parameter int CORE_NUM = CORE_NUM_DEF,
   parameter int DATA_WID = DATA_WID_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_mining_en,
   input  logic [DATA_WID-1:0]          iv_mining_extranounce2,
   output logic [CORE_NUM-1:0]          ov_core_start,
   output logic [CORE_NUM*DATA_WID-1:0] ov_core_nounce_base,
   output logic [CORE_NUM*DATA_WID-1:0] ov_core_nounce_last,
   output logic                         o_core_abort,
   input  logic [CORE_NUM-1:0]          iv_core_nounce_vld,
   input  logic [CORE_NUM*DATA_WID-1:0] iv_core_nounce,
   output logic [CORE_NUM-1:0]          ov_core_ack,
   input  logic [CORE_NUM-1:0]          iv_core_done,
   output logic                         o_mining_nounce_vld,
   input  logic                         i_mining_nounce_rdy,
   output logic [DATA_WID-1:0]          ov_mining_nounce,
   output logic [DATA_WID-1:0]          ov_mining_extranounce2,
   output logic                         o_mining_nounce_full
);
   localparam int LG = $clog2(CORE_NUM);
   localparam int IW = ptr_wid(CORE_NUM);

   state_t              state, state_nx;
   logic                en_d;
   logic [CORE_NUM-1:0] done_mask;
   logic [IW-1:0]       ptr, gnt_idx;
   logic [CORE_NUM-1:0] gnt;
   logic [DATA_WID-1:0] xn2, out_nonce;
   logic                out_vld;
   logic                start_req, abort_req, full_req, grant_en, take;

   // slice k covers [k*S, k*S + S - 1] with S = 2^DATA_WID / CORE_NUM
   for (genvar k = 0; k < CORE_NUM; k++) begin : g_slice
      assign ov_core_nounce_base[k*DATA_WID +: DATA_WID] = DATA_WID'(k) << (DATA_WID - LG);
      assign ov_core_nounce_last[k*DATA_WID +: DATA_WID] = (DATA_WID'(k) << (DATA_WID - LG)) | ({DATA_WID{1'b1}} >> LG);
   end

   assign start_req = i_mining_en && !en_d;
   assign abort_req = (state == RUN) && !i_mining_en;
   assign full_req  = (state == RUN) && i_mining_en && (&done_mask) && !(|iv_core_nounce_vld) && !out_vld;
   assign grant_en  = (state == RUN) && i_mining_en && (!out_vld || i_mining_nounce_rdy);
   assign take      = grant_en && (|iv_core_nounce_vld);

   mining_job_scheduler_rr_arbiter #(.N(CORE_NUM)) u_arb (
      .req     (iv_core_nounce_vld),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state: abort beats completion while running
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start_req ? START : IDLE;
         START:   state_nx = RUN;
         RUN:     state_nx = abort_req ? ABORT : (full_req ? FULL : RUN);
         default: state_nx = IDLE;
      endcase
   end

   // state-decoded pulses and the grant-cycle ack
   always_comb begin
      ov_core_start        = (state == START) ? '1 : '0;
      o_core_abort         = (state == ABORT);
      o_mining_nounce_full = (state == FULL);
      ov_core_ack          = grant_en ? gnt : '0;
   end

   // edge detect, job latch and slice-exhaustion tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_d      <= 1'b0;
         xn2       <= '0;
         done_mask <= '0;
      end else begin
         en_d <= i_mining_en;
         if (state == IDLE && start_req) begin
            xn2       <= iv_mining_extranounce2;
            done_mask <= '0;
         end else if (state == RUN) begin
            done_mask <= done_mask | iv_core_done;
         end
      end
   end

   // single-entry result register; a pending result is dropped on abort
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld   <= 1'b0;
         out_nonce <= '0;
         ptr       <= '0;
      end else if (abort_req || state == ABORT) begin
         out_vld   <= 1'b0;
         out_nonce <= '0;
      end else if (take) begin
         out_vld   <= 1'b1;
         out_nonce <= iv_core_nounce[int'(gnt_idx)*DATA_WID +: DATA_WID];
         ptr       <= IW'((int'(gnt_idx) + 1) % CORE_NUM);
      end else if (out_vld && i_mining_nounce_rdy) begin
         out_vld <= 1'b0;
      end
   end

   assign o_mining_nounce_vld    = out_vld;
   assign ov_mining_nounce       = out_nonce;
   assign ov_mining_extranounce2 = xn2;
endmodule
